cell_window_builder: RTL and testbench
======================================

# cell_window_builder

Front-end stage that turns raster pixel streams into `instruction_t` words for the cell processor. It accepts one pixel pair per beat (channels A and B), buffers the two previous image rows, and forms a 3x3 neighbourhood window for every interior pixel position. Each window is packed with a per-frame opcode and immediate into one instruction word, which is presented on a valid/ready output. It sits directly upstream of the cell processor.

## Interface
- `IMG_WIDTH`, default 64: pixels per row; must be ≥3.
- `IMG_HEIGHT`, default 64: rows per frame; must be ≥3.
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `pix_valid` in 1: input beat valid.
- `pix_ready` out 1: input beat accepted when `pix_valid && pix_ready`.
- `sof` in 1: start of frame; qualifies the accepted beat as pixel (0,0).
- `pixA` in channelDepth: channel-A pixel.
- `pixB` in channelDepth: channel-B pixel.
- `op_in` in opcode field width: opcode, sampled at the sof beat.
- `user_in` in channelDepth: immediate, sampled at the sof beat.
- `out_valid` out 1: `IW` holds a valid instruction.
- `out_ready` in 1: downstream accepts `IW` when `out_valid && out_ready`.
- `IW` out instruction_t: cellA/cellB 3x3 windows, opcode, userInputA.
- `frame_done` out 1: one-cycle pulse when the last window of a frame is accepted.

## Operation
- Row counter `r` and column counter `c` track the position of each accepted pixel.
  - `c` wraps at IMG_WIDTH-1 to 0 and increments `r`.
- Per channel, two line buffers of depth IMG_WIDTH hold rows r-1 and r-2, addressed by `c`.
- Per channel, a 3x3 window register shifts one column per accepted beat.
  - New column = {row r-2[c], row r-1[c], current pixel}.
- A window is emitted for an accepted pixel with r≥2 and c≥2.
  - Window center is image pixel (r-1, c-1).
  - `pixelMatrix[i][j]` = image pixel (r-2+i, c-2+j); `centerPixel` = 1.
- Emissions per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). No border windows.
- Opcode and immediate are latched at the sof beat and are constant for the whole frame.
- FSM states:
  - IDLE: pixels without sof are accepted and dropped. A sof beat moves to ACTIVE and is processed as (0,0).
  - ACTIVE: processes pixels. Acceptance of (IMG_HEIGHT-1, IMG_WIDTH-1) moves to DRAIN.
  - DRAIN: `pix_ready`=0 until the final window is accepted; then pulse `frame_done` and move to IDLE.
- Sof accepted in ACTIVE: the frame is aborted.
  - Counters restart at (0,0) with that beat; opcode and immediate are relatched.
  - An already pending output stays valid until accepted.
  - No `frame_done` is generated for the aborted frame.
- Sof asserted in DRAIN is not accepted, because `pix_ready`=0.
- Reset values: `out_valid`=0, `IW`=all zeros, `frame_done`=0, counters 0, state IDLE. Line buffer contents are don't-care.
- Reset mid-frame discards all state; the pending output is dropped.

## Timing
- Output latency: `IW`/`out_valid` update on the clock edge that accepts the completing pixel (1 cycle).
- Single output register: `pix_ready` = !rst && state≠DRAIN && (!out_valid || out_ready).
- Full throughput: one pixel per cycle while `out_ready`=1.
- `IW` must be held stable while `out_valid && !out_ready`.
- `frame_done` asserts the cycle after the final output handshake.
- Line-buffer read and write to the same address in one cycle: the read returns the old data (read-before-write).

## Configuration
- `CELL_B_EN` defined: channel B gets its own line buffers and window; `IW.cellB` carries the channel-B window.
- `CELL_B_EN` undefined: `pixB` is ignored, no channel-B storage is instantiated, and `IW.cellB` = `IW.cellA` bit-for-bit.

## Structure
- CellProcessingPkg provides `pixel_t`, `instruction_t`, the opcode enum, `channelDepth` and `centerPixel`.
- Add to CellProcessingPkg: `kernelSize` = 3, a window typedef if not already present, and the builder FSM state enum.
- One sub-module, `cell_line_buffer`: two-row buffer plus 3x3 shift window for one channel. Instantiated once, or twice with `CELL_B_EN`.

## Test plan
- 4x4 frame (IMG_WIDTH=IMG_HEIGHT=4), pixA = 4r+c, `out_ready`=1 -> exactly 4 outputs with centers 5, 6, 9, 10; first cellA rows {0,1,2}, {4,5,6}, {8,9,10}; then one `frame_done` pulse.
- Same frame with `out_ready` held low for 3 cycles after the first output -> `pix_ready`=0 during the stall, `IW` unchanged, no windows lost or duplicated.
- `op_in`=ADDI, `user_in`=7 at sof, `op_in` changed to SUB mid-frame -> every output in the frame has opcode ADDI and userInputA=7.
- Sof reasserted at pixel (2,1) -> restart; next outputs follow new-frame coordinates; no `frame_done` for the aborted frame.
- `rst` for one cycle mid-frame -> next cycle `out_valid`=0, `IW`=0; the following sof frame is correct.
- `CELL_B_EN` off with pixB = 255 constant -> cellB equals cellA on every output; with `CELL_B_EN` on, every cellB element is 255.

Source files
------------

// File: rtl/cell_window_builder_pkg.sv
// CellProcessingPkg: shared types for the cell processor front end.
// Pixel/instruction formats, opcode set, 3x3 window type and the
// window-builder FSM state encoding.
package CellProcessingPkg;

  localparam int channelDepth = 8;
  localparam int opcodeWidth  = 4;
  localparam int kernelSize   = 3;
  localparam int centerPixel  = 1;

  typedef logic [channelDepth-1:0] pixel_t;

  typedef enum logic [opcodeWidth-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADDI = 4'd2,
    OP_SUB  = 4'd3,
    OP_MUL  = 4'd4,
    OP_PASS = 4'd5
  } opcode_t;

  // pixelMatrix[i][j] is the pixel at row offset i, column offset j
  typedef struct packed {
    pixel_t [kernelSize-1:0][kernelSize-1:0] pixelMatrix;
  } window_t;

  typedef struct packed {
    window_t cellA;
    window_t cellB;
    opcode_t opcode;
    pixel_t  userInputA;
  } instruction_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } builder_state_t;

endpackage

// File: rtl/cell_window_builder_line_buffer.sv
// cell_line_buffer: two-row line store plus 3x3 shift window for one channel.
// win_next is the window as it will look after the current beat shifts in,
// so the parent can register it on the same edge that accepts the pixel.
module cell_line_buffer
  import CellProcessingPkg::*;
#(
  parameter int IMG_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         shift_en,
  input  logic [$clog2(IMG_WIDTH)-1:0] col,
  input  pixel_t                       pix,
  output window_t                      win_next
);

  pixel_t  row1 [IMG_WIDTH];
  pixel_t  row2 [IMG_WIDTH];
  window_t win;
  pixel_t  rd1;
  pixel_t  rd2;

  assign rd1 = row1[col];
  assign rd2 = row2[col];

  // Next window: drop the oldest column, append {row r-2, row r-1, current}
  always_comb begin
    win_next = win;
    for (int i = 0; i < kernelSize; i++) begin
      win_next.pixelMatrix[i][0] = win.pixelMatrix[i][1];
      win_next.pixelMatrix[i][1] = win.pixelMatrix[i][2];
    end
    win_next.pixelMatrix[0][2] = rd2;
    win_next.pixelMatrix[1][2] = rd1;
    win_next.pixelMatrix[2][2] = pix;
  end

  // Shift window and age the line buffers; reads see pre-write contents
  always_ff @(posedge clk) begin
    if (shift_en) begin
      win       <= win_next;
      row2[col] <= rd1;
      row1[col] <= pix;
    end
  end

endmodule

// File: rtl/cell_window_builder.sv
// cell_window_builder: raster pixel pairs in, one instruction_t per interior
// 3x3 window out on a valid/ready port with a single output register.
// Optional macro CELL_B_EN: independent channel-B window; otherwise
// IW.cellB mirrors IW.cellA and pixB is ignored.
module cell_window_builder
  import CellProcessingPkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic                   sof,
  input  pixel_t                 pixA,
  input  pixel_t                 pixB,
  input  logic [opcodeWidth-1:0] op_in,
  input  pixel_t                 user_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output instruction_t           IW,
  output logic                   frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  builder_state_t state;
  logic [CW-1:0]  c;
  logic [RW-1:0]  r;
  logic [CW-1:0]  cur_c;
  logic [RW-1:0]  cur_r;
  opcode_t        op_reg;
  pixel_t         user_reg;
  logic           accept;
  logic           proc;
  logic           emit;
  logic           last;
  logic           vld_p1;
  instruction_t   iw_p1;
  window_t        win_a_next;
  window_t        win_b_next;

  assign pix_ready = !rst && (state != ST_DRAIN) && (!vld_p1 || out_ready);
  assign accept    = pix_valid && pix_ready;
  // A sof beat is always pixel (0,0), whether it starts or aborts a frame
  assign proc      = accept && (sof || state == ST_ACTIVE);
  assign cur_c     = sof ? '0 : c;
  assign cur_r     = sof ? '0 : r;
  assign emit      = proc && (cur_r >= RW'(2)) && (cur_c >= CW'(2));
  assign last      = proc && (cur_r == RW'(IMG_HEIGHT-1)) && (cur_c == CW'(IMG_WIDTH-1));

  assign out_valid = vld_p1;
  assign IW        = iw_p1;

  cell_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lb_a (
    .clk      (clk),
    .shift_en (proc),
    .col      (cur_c),
    .pix      (pixA),
    .win_next (win_a_next)
  );

`ifdef CELL_B_EN
  cell_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lb_b (
    .clk      (clk),
    .shift_en (proc),
    .col      (cur_c),
    .pix      (pixB),
    .win_next (win_b_next)
  );
`else
  logic unused_pix_b;
  assign unused_pix_b = ^pixB;
  assign win_b_next   = win_a_next;
`endif

  // Per-frame opcode and immediate, captured on every accepted sof beat
  always_ff @(posedge clk) begin
    if (accept && sof) begin
      op_reg   <= opcode_t'(op_in);
      user_reg <= user_in;
    end
  end

  // Control FSM, position counters and the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      r          <= '0;
      c          <= '0;
      vld_p1     <= 1'b0;
      iw_p1      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (proc) begin
        if (cur_c == CW'(IMG_WIDTH-1)) begin
          c <= '0;
          r <= (cur_r == RW'(IMG_HEIGHT-1)) ? '0 : cur_r + RW'(1);
        end else begin
          c <= cur_c + CW'(1);
          r <= cur_r;
        end
      end
      // stage p1: completed window registered with the beat that finishes it
      if (emit) begin
        vld_p1 <= 1'b1;
        iw_p1  <= '{cellA: win_a_next, cellB: win_b_next,
                    opcode: op_reg, userInputA: user_reg};
      end else if (vld_p1 && out_ready) begin
        vld_p1 <= 1'b0;
      end
      case (state)
        ST_IDLE:   if (proc) state <= ST_ACTIVE;
        ST_ACTIVE: if (last) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (vld_p1 && out_ready) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
          end
        end
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_window_builder.sv
// Directed bench for cell_window_builder on a 4x4 image, pixA = 4r+c,
// pixB = 255. Honors CELL_B_EN for the cellB expectations.
module tb_cell_window_builder;
  import CellProcessingPkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   pix_valid;
  logic                   pix_ready;
  logic                   sof;
  pixel_t                 pixA;
  pixel_t                 pixB;
  logic [opcodeWidth-1:0] op_in;
  pixel_t                 user_in;
  logic                   out_valid;
  logic                   out_ready;
  instruction_t           IW;
  logic                   frame_done;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  cell_window_builder #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .sof        (sof),
    .pixA       (pixA),
    .pixB       (pixB),
    .op_in      (op_in),
    .user_in    (user_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .IW         (IW),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected window centred on image pixel (cr,cc) of the 4r+c ramp
  function automatic window_t ramp_win(input int cr, input int cc);
    window_t w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w.pixelMatrix[i][j] = pixel_t'(4 * (cr - 1 + i) + (cc - 1 + j));
    return w;
  endfunction

  function automatic window_t b_win(input int cr, input int cc);
    window_t w;
`ifdef CELL_B_EN
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w.pixelMatrix[i][j] = 8'hFF;
`else
    w = ramp_win(cr, cc);
`endif
    return w;
  endfunction

  // One beat: drive at negedge, accepted at posedge, sampled 1 time unit later
  task automatic send(input int val, input bit s);
    @(negedge clk);
    pix_valid = 1'b1;
    pixA      = pixel_t'(val);
    sof       = s;
    #1;
    chk("pix_ready_beat", pix_ready, 1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    chk("frame_done_idle", frame_done, 0);
  endtask

  task automatic check_out(input int cr, input int cc, input opcode_t op, input pixel_t usr);
    chk("out_valid", out_valid, 1);
    chk("cellA", IW.cellA, ramp_win(cr, cc));
    chk("center", IW.cellA.pixelMatrix[centerPixel][centerPixel], 4 * cr + cc);
    chk("cellB", IW.cellB, b_win(cr, cc));
    chk("opcode", IW.opcode, op);
    chk("userInputA", IW.userInputA, usr);
  endtask

  // Full 4x4 frame starting with a sof beat; op/imm change after the sof beat
  task automatic frame(input bit stall, input opcode_t op, input pixel_t usr);
    int first_rows [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    instruction_t saved;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r == 0 && c == 0) begin
          op_in   = op;
          user_in = usr;
        end else begin
          op_in   = (op == OP_SUB) ? OP_ADDI : OP_SUB;
          user_in = usr + 8'd1;
        end
        send(4 * r + c, (r == 0 && c == 0));
        if (r >= 2 && c >= 2) check_out(r - 1, c - 1, op, usr);
        else chk("no_window", out_valid, 0);
        if (r == 2 && c == 2) begin
          for (int k = 0; k < 9; k++)
            chk("first_rows", IW.cellA.pixelMatrix[k / 3][k % 3], first_rows[k]);
          if (stall) begin
            saved     = IW;
            out_ready = 1'b0;
            pix_valid = 1'b1;
            pixA      = 8'd11;
            repeat (3) begin
              @(posedge clk);
              #1;
              chk("stall_pix_ready", pix_ready, 0);
              chk("stall_valid", out_valid, 1);
              chk("stall_iw", IW, saved);
            end
            pix_valid = 1'b0;
            out_ready = 1'b1;
          end
        end
      end
    end
    chk("drain_pix_ready", pix_ready, 0);
    chk("drain_done_low", frame_done, 0);
    @(posedge clk);
    #1;
    chk("drain_valid_clear", out_valid, 0);
    chk("frame_done_pulse", frame_done, 1);
    chk("idle_pix_ready", pix_ready, 1);
    @(posedge clk);
    #1;
    chk("frame_done_end", frame_done, 0);
  endtask

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    pixA      = '0;
    pixB      = 8'hFF;
    op_in     = OP_NOP;
    user_in   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_iw", IW, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pix_ready", pix_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_pix_ready", pix_ready, 1);

    // beats without sof in IDLE are dropped
    send(77, 1'b0);
    send(78, 1'b0);
    chk("idle_drop_valid", out_valid, 0);

    // basic frame at full throughput, opcode changes after sof are ignored
    frame(1'b0, OP_ADDI, 8'd7);

    // same frame with a 3-cycle downstream stall after the first window
    frame(1'b1, OP_SUB, 8'd9);

    // abort: old frame runs to (2,0), sof lands where (2,1) would be
    op_in   = OP_SUB;
    user_in = 8'd1;
    for (int k = 0; k < 9; k++) begin
      send(100 + k, (k == 0));
      chk("abort_old_no_window", out_valid, 0);
    end
    frame(1'b0, OP_ADDI, 8'd5);

    // reset mid-frame with an output pending
    op_in   = OP_ADDI;
    user_in = 8'd7;
    for (int k = 0; k < 11; k++) send(4 * (k / 4) + (k % 4), (k == 0));
    chk("pre_rst_valid", out_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_pix_ready", pix_ready, 0);
    @(posedge clk);
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_iw", IW, 0);
    chk("rst_mid_frame_done", frame_done, 0);
    @(negedge clk);
    rst = 1'b0;
    frame(1'b0, OP_MUL, 8'd200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
